// File: rtl/bg_pixel_fetch.sv
// bg_pixel_fetch: background frame RAM read side feeding the VGA display
// Ports:
//    clk_vga, rst                 pixel clock, synchronous active-high reset
//    frame_start, addr_ena        display timing: frame pulse, picture-window enable
//    scroll_x                     horizontal scroll in columns, latched on frame_start
//    ram_addr, ram_rd, ram_dout   pixel BRAM read port (data RAM_LAT cycles after ram_rd)
//    color_data_out, color_valid  fetched RGB565 pixel and its strobe
//    line_done, frame_done        one-cycle completion pulses
//    err_overrun                  sticky: fetch request after frame end or illegal scroll
module bg_pixel_fetch #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int ADDR_W  = 19,
   parameter int RAM_LAT = 1
) (
   input  logic              clk_vga,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              addr_ena,
   input  logic [11:0]       scroll_x,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [15:0]       ram_dout,
   output logic [15:0]       color_data_out,
   output logic              color_valid,
   output logic              line_done,
   output logic              frame_done,
   output logic              err_overrun
);
   localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
   localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
   localparam logic [12:0]       W1 = 13'(IMG_W);
   localparam logic [12:0]       W2 = 13'(2 * IMG_W);
   localparam logic [CW-1:0]     CL = CW'(IMG_W - 1);
   localparam logic [RW-1:0]     RL = RW'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] AW = ADDR_W'(IMG_W);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       s_q, s_d, col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
   logic                rd_q, rd_d, ena_q, ena_d, ld_q, ld_d, fd_q, fd_d, err_q, err_d;
   logic [RAM_LAT-1:0]  vld_q;
   logic [15:0]         color_q;
   logic                cv_q;
   logic [12:0]         sx;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      addr_d  = addr_q;
      err_d   = err_q;
      rd_d    = 1'b0;
      ena_d   = 1'b0;
      ld_d    = 1'b0;
      fd_d    = 1'b0;
      sx      = {1'b0, scroll_x};
      if (frame_start) begin
         // frame_start beats a coincident addr_ena; the pipeline is left untouched
         state_d = ACTIVE;
         row_d   = '0;
         base_d  = '0;
         s_d     = CW'(sx < W1 ? sx : sx < W2 ? sx - W1 : 13'd0);
         col_d   = s_d;
         err_d   = err_q | (sx >= W2);
      end else if (state_q == ACTIVE) begin
         // ena_q only tracks issued fetches, so a line ends only after real fetches
         ena_d = addr_ena;
         if (addr_ena) begin
            rd_d   = 1'b1;
            addr_d = base_q + ADDR_W'(col_q);
            col_d  = col_q == CL ? '0 : col_q + 1'b1;
         end else if (ena_q) begin
            col_d  = s_q;
            ld_d   = 1'b1;
            row_d  = row_q + 1'b1;
            base_d = base_q + AW;
            fd_d   = row_q == RL;
            state_d = row_q == RL ? DONE : ACTIVE;
         end
      end else if (state_q == DONE && addr_ena) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         ena_q   <= 1'b0;
         ld_q    <= 1'b0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
         vld_q   <= '0;
         color_q <= '0;
         cv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         ena_q   <= ena_d;
         ld_q    <= ld_d;
         fd_q    <= fd_d;
         err_q   <= err_d;
         // valid bit travels alongside the RAM read so it lines up with ram_dout
         vld_q   <= RAM_LAT'({vld_q, rd_q});
         cv_q    <= vld_q[RAM_LAT-1];
         color_q <= vld_q[RAM_LAT-1] ? ram_dout : 16'd0;
      end
   end

   assign ram_addr       = addr_q;
   assign ram_rd         = rd_q;
   assign color_data_out = color_q;
   assign color_valid    = cv_q;
   assign line_done      = ld_q;
   assign frame_done     = fd_q;
   assign err_overrun    = err_q;
endmodule

// File: tb/tb_bg_pixel_fetch.sv
// tb_bg_pixel_fetch: scoreboard bench for bg_pixel_fetch with a latency-1 RAM model mem[a]=a
module tb_bg_pixel_fetch;
   logic        clk = 0;
   logic        rst = 1;
   logic        frame_start = 0;
   logic        addr_ena = 0;
   logic [11:0] scroll_x = 0;
   logic [4:0]  ram_addr;
   logic        ram_rd;
   logic [15:0] ram_dout = 0;
   logic [15:0] color_data_out;
   logic        color_valid, line_done, frame_done, err_overrun;

   int checks = 0;
   int errors = 0;
   int exp_addr[$];
   int exp_color[$];
   bit exp_fd[$];

   bg_pixel_fetch #(.IMG_W(8), .IMG_H(4), .ADDR_W(5), .RAM_LAT(1)) dut (
      .clk_vga(clk), .rst(rst), .frame_start(frame_start), .addr_ena(addr_ena),
      .scroll_x(scroll_x), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_dout(ram_dout),
      .color_data_out(color_data_out), .color_valid(color_valid), .line_done(line_done),
      .frame_done(frame_done), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_rd) ram_dout <= {11'd0, ram_addr};

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (ram_rd) begin
         if (exp_addr.size() == 0) chk("unexpected_ram_rd", 1, 0);
         else chk("ram_addr", int'(ram_addr), exp_addr.pop_front());
      end
      if (color_valid) begin
         if (exp_color.size() == 0) chk("unexpected_color", 1, 0);
         else chk("color", int'(color_data_out), exp_color.pop_front());
      end else if (color_data_out != 0) chk("color_idle_zero", int'(color_data_out), 0);
      if (line_done) begin
         if (exp_fd.size() == 0) chk("unexpected_line_done", 1, 0);
         else chk("frame_done_with_line", int'(frame_done), int'(exp_fd.pop_front()));
      end else if (frame_done) chk("frame_done_alone", 1, 0);
   end

   task automatic fs(input int sx);
      scroll_x = 12'(sx);
      frame_start = 1;
      @(posedge clk); #1 frame_start = 0;
   endtask

   task automatic line(input int base, input int s, input bit fd);
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(base + (s + i) % 8);
         exp_color.push_back(base + (s + i) % 8);
      end
      exp_fd.push_back(fd);
      for (int i = 0; i < 8; i++) begin
         addr_ena = 1;
         @(posedge clk); #1;
      end
      addr_ena = 0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string name);
      chk({name, "_addr"}, int'(ram_addr), 0);
      chk({name, "_rd"}, int'(ram_rd), 0);
      chk({name, "_color"}, int'(color_data_out), 0);
      chk({name, "_valid"}, int'(color_valid), 0);
      chk({name, "_ld"}, int'(line_done), 0);
      chk({name, "_fd"}, int'(frame_done), 0);
      chk({name, "_err"}, int'(err_overrun), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 all_zero("reset");
      rst = 0;
      @(posedge clk); #1;
      // test 1: no scroll
      fs(0);
      line(0, 0, 0);
      // test 2: scroll 5, two lines
      fs(5);
      line(0, 5, 0);
      line(8, 5, 0);
      // test 3: full frame, then overrun in DONE
      fs(0);
      line(0, 0, 0);
      line(8, 0, 0);
      line(16, 0, 0);
      line(24, 0, 1);
      chk("err_before_overrun", int'(err_overrun), 0);
      for (int i = 0; i < 8; i++) begin
         addr_ena = 1;
         @(posedge clk); #1;
      end
      addr_ena = 0;
      repeat (3) @(posedge clk);
      #1 chk("err_overrun_done", int'(err_overrun), 1);
      // test 4: scroll wrap and illegal scroll
      rst = 1;
      @(posedge clk); #1 rst = 0;
      chk("err_cleared_by_rst", int'(err_overrun), 0);
      fs(11);
      line(0, 3, 0);
      chk("err_scroll11", int'(err_overrun), 0);
      fs(20);
      chk("err_scroll20", int'(err_overrun), 1);
      line(0, 0, 0);
      // test 5: reset mid line 2
      rst = 1;
      @(posedge clk); #1 rst = 0;
      fs(0);
      line(0, 0, 0);
      exp_addr.push_back(8);
      exp_addr.push_back(9);
      exp_addr.push_back(10);
      exp_color.push_back(8);
      for (int i = 0; i < 3; i++) begin
         addr_ena = 1;
         @(posedge clk); #1;
      end
      rst = 1;
      addr_ena = 0;
      @(posedge clk); #1 all_zero("midline_rst");
      rst = 0;
      fs(0);
      line(0, 0, 0);
      // test 6: frame_start together with addr_ena mid-frame
      line(8, 0, 0);
      scroll_x = 12'd2;
      frame_start = 1;
      addr_ena = 1;
      @(posedge clk); #1;
      frame_start = 0;
      addr_ena = 0;
      @(posedge clk); #1;
      chk("no_fetch_on_frame_start", int'(ram_rd), 0);
      line(0, 2, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("addr_queue_empty", exp_addr.size(), 0);
      chk("color_queue_empty", exp_color.size(), 0);
      chk("line_queue_empty", exp_fd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
